// File: rtl/tick_counter_if.sv
// tick_counter_if: control/status bundle for tick_counter.
//   master: drives iEnable, iClear, iLoad, iLoadVal, iDown, iStep;
//           observes oCount, oTick, oWrap, oRunning.
//   slave : the counter side of the same signals.
`timescale 1ns/1ps
interface tick_counter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             iEnable;
  logic             iClear;
  logic             iLoad;
  logic [WIDTH-1:0] iLoadVal;
  logic             iDown;
  logic             iStep;
  logic [WIDTH-1:0] oCount;
  logic             oTick;
  logic             oWrap;
  logic             oRunning;

  modport master (
    output iEnable, iClear, iLoad, iLoadVal, iDown, iStep,
    input  oCount, oTick, oWrap, oRunning
  );

  modport slave (
    input  iEnable, iClear, iLoad, iLoadVal, iDown, iStep,
    output oCount, oTick, oWrap, oRunning
  );
endinterface

// File: rtl/tick_counter.sv
// tick_counter: prescaled up/down event counter with wrap or saturate.
//   iClk_50 : clock, rising edge
//   nRst    : asynchronous active-low reset
//   bus     : tick_counter_if.slave (enable/clear/load/direction/step in,
//             registered count, tick/wrap strobes and running flag out)
`timescale 1ns/1ps
module tick_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MODULUS  = 256,
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter bit          SATURATE = 1'b0
) (
  input  logic          iClk_50,
  input  logic          nRst,
  tick_counter_if.slave bus
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW    = WIDTH + 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CW-1:0]    TOP      = CW'(MODULUS - 1);
  localparam logic [CW-1:0]    MOD_EXT  = CW'(MODULUS);

  logic [PRE_W-1:0] pre;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             wrap;
  logic             running;

  logic             prescale_done_c;
  logic             step_c;
  logic [CW-1:0]    cnt_ext_c;
  logic [CW-1:0]    load_ext_c;
  logic [CW-1:0]    next_cnt_c;
  logic             next_wrap_c;

  // Step request and next count; one extra bit keeps the down path free of underflow.
  always_comb begin
    prescale_done_c = bus.iEnable && (pre == PRE_LAST);
    step_c          = prescale_done_c || bus.iStep;
    cnt_ext_c       = {1'b0, count};
    load_ext_c      = {1'b0, bus.iLoadVal};
    next_cnt_c      = cnt_ext_c;
    next_wrap_c     = 1'b0;
    if (bus.iDown) begin
      if (cnt_ext_c != '0) begin
        next_cnt_c = cnt_ext_c - CW'(1);
      end else begin
        next_wrap_c = 1'b1;
        if (!SATURATE) next_cnt_c = TOP;
      end
    end else begin
      if (cnt_ext_c < TOP) begin
        next_cnt_c = cnt_ext_c + CW'(1);
      end else begin
        next_wrap_c = 1'b1;
        if (!SATURATE) next_cnt_c = '0;
      end
    end
  end

  // Prescaler, count and strobes; clear beats load beats step.
  always_ff @(posedge iClk_50 or negedge nRst) begin
    if (!nRst) begin
      pre     <= '0;
      count   <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
      running <= 1'b0;
    end else begin
      running <= bus.iEnable;
      tick    <= 1'b0;
      wrap    <= 1'b0;
      if (bus.iClear) begin
        count <= '0;
        pre   <= '0;
      end else if (bus.iLoad) begin
        count <= (load_ext_c >= MOD_EXT) ? WIDTH'(TOP) : bus.iLoadVal;
        pre   <= '0;
      end else begin
        // Prescaler freezes while disabled so a paused period resumes intact.
        if (bus.iEnable) pre <= (pre == PRE_LAST) ? '0 : pre + PRE_W'(1);
        if (step_c) begin
          count <= WIDTH'(next_cnt_c);
          tick  <= 1'b1;
          wrap  <= next_wrap_c;
        end
      end
    end
  end

  assign bus.oCount   = count;
  assign bus.oTick    = tick;
  assign bus.oWrap    = wrap;
  assign bus.oRunning = running;

endmodule

// File: doc/tick_counter.md
# tick_counter

Parametrised prescaled event counter for the DE2 display and VGA demos. It is the generalised successor to the fixed 1 Hz, 8-bit display counter in the DE2 top levels. It adds configurable width, modulus and tick period, up/down counting, pause without loss, synchronous clear/load, manual single-step, and wrap or saturate modes. `oCount` drives the seven-segment driver's `iNum` or VGA pattern selection directly. `oTick` and `oWrap` are available as timebase strobes for other blocks.

## Interface
- `WIDTH`, default 8: counter width in bits.
- `MODULUS`, default 256: count range is 0..MODULUS-1. Legal range is 2 ≤ MODULUS ≤ 2^WIDTH.
- `TICK_DIV`, default 50_000_000: enabled `iClk_50` cycles per count step (1 Hz at 50 MHz). Must be ≥ 1.
- `SATURATE`, default 0: 0 = wrap at the range ends; 1 = hold at the range ends.

Ports:
- `iClk_50`, input, 1: the only clock; all logic is on its rising edge.
- `nRst`, input, 1: asynchronous, active-low reset.
- `iEnable`, input, 1: run. When low, the prescaler and count hold their values; they are not cleared.
- `iClear`, input, 1: synchronous clear of the count and the prescaler.
- `iLoad`, input, 1: synchronous load of `iLoadVal`.
- `iLoadVal`, input, WIDTH: load value.
- `iDown`, input, 1: 0 = count up; 1 = count down.
- `iStep`, input, 1: single-cycle pulse requesting one manual step. Honoured regardless of `iEnable`.
- `oCount`, output, WIDTH: current count.
- `oTick`, output, 1: one-cycle strobe marking a count step.
- `oWrap`, output, 1: one-cycle strobe marking a wrap, or a blocked step when saturating.
- `oRunning`, output, 1: registered copy of `iEnable`.

## Operation
- Prescaler `pre`:
  - Width is clog2(TICK_DIV), with a minimum of 1.
  - While `iEnable`=1, it counts 0..TICK_DIV-1 and then returns to 0.
  - `prescale_done` = `iEnable` && `pre`==TICK_DIV-1.
  - If TICK_DIV=1, `prescale_done` = `iEnable` on every cycle.
- Step request: `step` = `prescale_done` || `iStep`. A coincident prescaler step and manual step produce exactly one step.
- Priority on each edge is `iClear` > `iLoad` > `step` > hold.
  - `iClear`: `oCount`←0 and `pre`←0. No strobes.
  - `iLoad`: `oCount`←`iLoadVal`, clamped to MODULUS-1 if `iLoadVal` ≥ MODULUS. `pre`←0. No strobes. A concurrent step is discarded.
  - `step` while counting up:
    - If `oCount`<MODULUS-1, then `oCount`+1.
    - Otherwise, `oCount`←0 (SATURATE=0) or hold (SATURATE=1), and `oWrap` is asserted in both cases.
  - `step` while counting down:
    - If `oCount`>0, then `oCount`-1.
    - Otherwise, `oCount`←MODULUS-1 (SATURATE=0) or hold (SATURATE=1), and `oWrap` is asserted.
- `oTick` is asserted for every accepted step, including a step blocked by saturation.
- `iDown` is sampled on the step edge, so a direction change takes effect on the next step.
- Arithmetic is done in WIDTH+1 bits with no unsigned underflow. The terminal compare uses MODULUS-1, never 2^WIDTH-1, unless MODULUS=2^WIDTH.
- Pause and resume: dropping `iEnable` freezes `pre`. Raising it again resumes from the frozen value, so partial periods are preserved.

## Timing
- Reset, asynchronous on `nRst`=0: `oCount`=0, `pre`=0, `oTick`=0, `oWrap`=0, `oRunning`=0. Releasing `nRst` mid-period restarts the count from 0.
- All outputs are registered, with no combinational path from input to output.
- Latency:
  - `oCount` changes on the edge where `step`, `iClear` or `iLoad` is sampled.
  - `oTick` and `oWrap` are high during the cycle that follows that edge, coincident with the new `oCount`, for exactly one cycle.
- Step period: with `iEnable` held high and no other input active, `oTick` pulses are exactly TICK_DIV cycles apart.
- After a clear or load, the first prescaled step arrives TICK_DIV enabled cycles later.
- `oRunning` lags `iEnable` by one cycle.
- `iStep` held high for N cycles produces N steps; a single step requires a one-cycle pulse.

## Test plan
Bench parameters are WIDTH=4, MODULUS=10, TICK_DIV=4, SATURATE=0 unless noted.
- Reset, then `iEnable`=1 for 44 cycles → `oCount` reads 1,2,…,9,0,1. `oTick` pulses every 4 cycles. `oWrap` pulses exactly once, coincident with `oCount`=0.
- `iDown`=1 from `oCount`=0, one step → `oCount`=9 and `oWrap`=1. SATURATE=1 repeat → `oCount` stays 0, with `oTick`=1 and `oWrap`=1.
- `iLoad`=1 with `iLoadVal`=13 → `oCount`=9 (clamped). `iLoad` and `iClear` together → `oCount`=0. `iLoad` coincident with `prescale_done` → `oCount`=`iLoadVal`, no `oTick`.
- Enabled 2 cycles into a period, `iEnable`=0 for 20 cycles, then `iEnable`=1 → next `oTick` after 2 more enabled cycles; `oCount` unchanged during the pause.
- `iStep` pulse with `iEnable`=0 → `oCount`+1 and one `oTick`. `iStep` coincident with `prescale_done` → increment of exactly 1.
- Assert `nRst`=0 asynchronously mid-period at `oCount`=7 → all outputs 0 immediately. After release, the first `oTick` arrives 4 cycles later.
